// File: rtl/fuzzy_pwm_sequencer_if.sv
// Sequencer <-> ADC/inference-core signal bundle.
// master: the sequencer side (drives start and latched samples).
// slave:  the ADC/core side (drives samples, valid, done and pulse width).
interface fuzzy_pwm_sequencer_if;
  logic [7:0]  v1;
  logic [7:0]  v2;
  logic        adc_valid;
  logic        core_done;
  logic [11:0] core_pw;
  logic        core_start;
  logic [7:0]  core_v1;
  logic [7:0]  core_v2;

  modport master (
    input  v1, v2, adc_valid, core_done, core_pw,
    output core_start, core_v1, core_v2
  );

  modport slave (
    output v1, v2, adc_valid, core_done, core_pw,
    input  core_start, core_v1, core_v2
  );
endinterface

// File: rtl/fuzzy_pwm_sequencer.sv
// Sample-rate sequencer and 12-bit PWM output stage for the fuzzy PWM core.
// A free-running sample timer kicks an IDLE->ARM->START->WAIT->APPLY
// sequence; the returned pulse width becomes pw_target, which the PWM
// generator adopts only at its period boundary.
// Build option: define SLEW_LIMIT_EN to limit each per-sample change of
// pw_target to SLEW_MAX; otherwise the core result is applied directly.
module fuzzy_pwm_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 64,
  parameter int SLEW_MAX   = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  fuzzy_pwm_sequencer_if.master        bus,
  input  logic                         fault_clr,
  output logic [11:0]                  pw,
  output logic                         pwm_out,
  output logic                         busy,
  output logic                         fault,
  output logic                         overrun
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [11:0] CNT_LAST = 12'd4094;

  // Reject parameter values the counters and slew arithmetic cannot honour.
  generate
    if (SAMPLE_DIV < 16 || TIMEOUT < 2 || SLEW_MAX < 1 || SLEW_MAX > 4095) begin : g_param_check
      $error("fuzzy_pwm_sequencer: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_WAIT, S_APPLY} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      v1_q, v1_d, v2_q, v2_d;
  logic            core_start_q, core_start_d;
  logic [11:0]     cap_pw_q, cap_pw_d;
  logic [11:0]     pw_target_q, pw_target_d;
  logic [11:0]     pw_q, pw_d;
  logic [11:0]     cnt_q, cnt_d;
  logic            pwm_out_q, pwm_out_d;
  logic            fault_q, fault_d;
  logic            overrun_q, overrun_d;
  logic            tick;
  logic            timeout;
  logic [11:0]     applied_pw;

  // Sample tick on the last timer count; timeout on the last allowed WAIT cycle.
  always_comb begin
    tick    = (timer_q == TW'(SAMPLE_DIV - 1));
    timeout = (state_q == S_WAIT) && (wait_q == WW'(TIMEOUT - 1));
  end

`ifdef SLEW_LIMIT_EN
  localparam logic signed [12:0] SLEW_S = 13'(SLEW_MAX);
  logic signed [12:0] slew_diff;

  // Move pw_target toward the captured core result by at most SLEW_MAX.
  always_comb begin
    slew_diff = $signed({1'b0, cap_pw_q}) - $signed({1'b0, pw_target_q});
    if (slew_diff > SLEW_S) begin
      applied_pw = pw_target_q + 12'(SLEW_MAX);
    end else if (slew_diff < -SLEW_S) begin
      applied_pw = pw_target_q - 12'(SLEW_MAX);
    end else begin
      applied_pw = cap_pw_q;
    end
  end
`else
  // Without slew limiting the captured core result is applied as-is.
  always_comb begin
    applied_pw = cap_pw_q;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in WAIT a done in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_ARM;
      S_ARM:   if (bus.adc_valid) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_done) begin
          state_d = S_APPLY;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: timer, wait counter, latches, flags and PWM.
  always_comb begin
    timer_d      = tick ? '0 : timer_q + TW'(1);
    core_start_d = (state_d == S_START);

    wait_d = wait_q;
    if (state_q == S_START) begin
      wait_d = '0;
    end else if (state_q == S_WAIT) begin
      wait_d = wait_q + WW'(1);
    end

    v1_d = v1_q;
    v2_d = v2_q;
    if (state_q == S_ARM && bus.adc_valid) begin
      v1_d = bus.v1;
      v2_d = bus.v2;
    end

    cap_pw_d = cap_pw_q;
    if (state_q == S_WAIT && bus.core_done) begin
      cap_pw_d = bus.core_pw;
    end

    pw_target_d = pw_target_q;
    if (state_q == S_APPLY) begin
      pw_target_d = applied_pw;
    end

    // Sticky flags: clear first so a same-cycle set wins.
    fault_d = fault_q;
    if (fault_clr) fault_d = 1'b0;
    if (timeout && !bus.core_done) fault_d = 1'b1;

    overrun_d = overrun_q;
    if (fault_clr) overrun_d = 1'b0;
    if (tick && state_q != S_IDLE) overrun_d = 1'b1;

    // PWM period is 4095 cycles; duty is reloaded on the last count so the
    // new value governs the whole next period starting at cnt = 0.
    cnt_d     = (cnt_q == CNT_LAST) ? 12'd0 : cnt_q + 12'd1;
    pw_d      = (cnt_q == CNT_LAST) ? pw_target_q : pw_q;
    pwm_out_d = (cnt_d < pw_d);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      wait_q       <= '0;
      v1_q         <= 8'd0;
      v2_q         <= 8'd0;
      core_start_q <= 1'b0;
      cap_pw_q     <= 12'd0;
      pw_target_q  <= 12'd0;
      pw_q         <= 12'd0;
      cnt_q        <= 12'd0;
      pwm_out_q    <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      wait_q       <= wait_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      core_start_q <= core_start_d;
      cap_pw_q     <= cap_pw_d;
      pw_target_q  <= pw_target_d;
      pw_q         <= pw_d;
      cnt_q        <= cnt_d;
      pwm_out_q    <= pwm_out_d;
      fault_q      <= fault_d;
      overrun_q    <= overrun_d;
    end
  end

  // Output drive: busy is decoded from state, everything else is a flop.
  always_comb begin
    busy           = (state_q != S_IDLE);
    bus.core_start = core_start_q;
    bus.core_v1    = v1_q;
    bus.core_v2    = v2_q;
    pw             = pw_q;
    pwm_out        = pwm_out_q;
    fault          = fault_q;
    overrun        = overrun_q;
  end

endmodule

// File: tb/tb_fuzzy_pwm_sequencer.sv
// Directed bench for fuzzy_pwm_sequencer (SAMPLE_DIV=100, TIMEOUT=8,
// SLEW_MAX=256). Expected pw_target values are tabulated for both builds.
module tb_fuzzy_pwm_sequencer;

  localparam int SD = 100;
  localparam int TO = 8;
  localparam int SM = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault_clr = 1'b0;
  logic [11:0] pw;
  logic        pwm_out, busy, fault, overrun;

  fuzzy_pwm_sequencer_if bus ();

  fuzzy_pwm_sequencer #(.SAMPLE_DIV(SD), .TIMEOUT(TO), .SLEW_MAX(SM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fault_clr (fault_clr),
    .pw        (pw),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .fault     (fault),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Main-process controls for the core model.
  int core_en    = 0;
  int resp_pw    = 0;
  int inject_req = 0;
  int inject_pw  = 0;
  // Core-model state (written only by the core model).
  int starts     = 0;
  int last_start = 0;
  int prev_start = 0;
  int inject_ack = 0;
  int cnt_down   = 0;

  typedef struct {
    int core_pw;
    int exp_slew;
    int exp_direct;
  } vec_t;

  vec_t tv[22];

  // Core model: answers each start with done 3 cycles later when enabled.
  initial begin
    bus.core_done = 1'b0;
    bus.core_pw   = 12'd0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (cnt_down > 0) begin
        cnt_down--;
        if (cnt_down == 0) begin
          bus.core_done = 1'b1;
          bus.core_pw   = 12'(resp_pw);
        end
      end
      if (bus.core_start === 1'b1) begin
        starts++;
        prev_start = last_start;
        last_start = cyc;
        if (core_en != 0) cnt_down = 3;
      end
      if (inject_req != inject_ack) begin
        inject_ack    = inject_req;
        bus.core_done = 1'b1;
        bus.core_pw   = 12'(inject_pw);
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 300) begin
      step;
      k++;
    end
  endtask

  // One full sample: wait for a start, let the reply be applied.
  task automatic run_sample(input int p);
    int old;
    int k = 0;
    wait_idle;
    old = starts;
    resp_pw = p;
    while (starts == old && k < 300) begin
      step;
      k++;
    end
    chk("start_seen", int'(starts != old), 1);
    repeat (6) step;
    $display("sample core_pw=%0d pw_target=%0d", p, dut.pw_target_q);
  endtask

  task automatic drive_to(input int t);
    for (int i = 0; i < 30; i++) begin
      run_sample(t);
      if (int'(dut.pw_target_q) == t) break;
    end
    chk("drive_to", int'(dut.pw_target_q), t);
  endtask

  task automatic wait_pw(input int t);
    int k = 0;
    while (int'(pw) != t && k < 4200) begin
      step;
      k++;
    end
    chk("pw_reached", int'(pw), t);
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (4095) begin
      step;
      if (pwm_out) n++;
    end
  endtask

  initial begin
    int n;
    int old;
    int k;
    int exp;

    for (int i = 0; i < 15; i++) begin
      tv[i] = '{4000, (i < 14) ? (456 + 256 * i) : 4000, 4000};
    end
    tv[15] = '{3900, 3900, 3900};
    tv[16] = '{0,    3644, 0};
    tv[17] = '{3500, 3500, 3500};
    tv[18] = '{3756, 3756, 3756};
    tv[19] = '{4095, 4012, 4095};
    tv[20] = '{4095, 4095, 4095};
    tv[21] = '{0,    3839, 0};

    bus.v1 = 8'd0;
    bus.v2 = 8'd0;
    bus.adc_valid = 1'b0;

    // Reset state.
    repeat (3) step;
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(bus.core_start), 0);
    chk("rst_pw", int'(pw), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // pw = 0: constant low for a full period.
    count_high(n);
    chk("pwm_zero", n, 0);
    fault_clr = 1'b1;
    repeat (2) step;
    fault_clr = 1'b0;

    // Nominal sequence.
    bus.v1 = 8'h80;
    bus.v2 = 8'h60;
    bus.adc_valid = 1'b1;
    core_en = 1;
    run_sample(200);
    chk("core_v1", int'(bus.core_v1), 8'h80);
    chk("core_v2", int'(bus.core_v2), 8'h60);
    chk("nom_target", int'(dut.pw_target_q), 200);
    run_sample(200);
    run_sample(200);
    chk("start_period", last_start - prev_start, SD);
    wait_pw(200);
    chk("pw_load_cnt", int'(dut.cnt_q), 0);

    // Slew / direct apply table.
    for (int i = 0; i < 22; i++) begin
      run_sample(tv[i].core_pw);
`ifdef SLEW_LIMIT_EN
      exp = tv[i].exp_slew;
`else
      exp = tv[i].exp_direct;
`endif
      chk($sformatf("apply_%0d", i), int'(dut.pw_target_q), exp);
    end

    // Timeout: no done, fault exactly TO cycles after WAIT entry.
    wait_idle;
    core_en = 0;
    old = starts;
    k = 0;
    while (starts == old && k < 300) begin
      step;
      k++;
    end
    chk("to_start_seen", int'(starts != old), 1);
    repeat (TO) step;
    chk("fault_early", int'(fault), 0);
    step;
    chk("fault_set", int'(fault), 1);
    chk("to_idle", int'(busy), 0);
`ifdef SLEW_LIMIT_EN
    chk("to_target_kept", int'(dut.pw_target_q), 3839);
`else
    chk("to_target_kept", int'(dut.pw_target_q), 0);
`endif
    core_en = 1;
    run_sample(1000);
`ifdef SLEW_LIMIT_EN
    chk("post_fault_apply", int'(dut.pw_target_q), 3583);
`else
    chk("post_fault_apply", int'(dut.pw_target_q), 1000);
`endif
    chk("fault_sticky", int'(fault), 1);
    fault_clr = 1'b1;
    step;
    fault_clr = 1'b0;
    chk("fault_clr", int'(fault), 0);

    // Overrun: adc_valid low across a second tick.
    wait_idle;
    bus.adc_valid = 1'b0;
    k = 0;
    while (!busy && k < 200) begin
      step;
      k++;
    end
    chk("ovr_arm", int'(busy), 1);
    chk("ovr_clear_at_arm", int'(overrun), 0);
    repeat (SD - 1) step;
    chk("ovr_early", int'(overrun), 0);
    step;
    chk("ovr_set", int'(overrun), 1);
    repeat (49) step;
    old = starts;
    bus.adc_valid = 1'b1;
    repeat (40) step;
    chk("ovr_one_start", starts - old, 1);
    fault_clr = 1'b1;
    repeat (2) step;
    fault_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // PWM extremes.
    drive_to(4095);
    wait_pw(4095);
    count_high(n);
    chk("pwm_full", n, 4095);
    drive_to(2048);
    wait_pw(2048);
    count_high(n);
    chk("pwm_half", n, 2048);

    // Asynchronous reset while in WAIT.
    wait_idle;
    core_en = 0;
    old = starts;
    k = 0;
    while (starts == old && k < 300) begin
      step;
      k++;
    end
    chk("rw_start_seen", int'(starts != old), 1);
    repeat (2) step;
    chk("rw_in_wait", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rw_busy", int'(busy), 0);
    chk("rw_pw", int'(pw), 0);
    chk("rw_target", int'(dut.pw_target_q), 0);
    chk("rw_v1", int'(bus.core_v1), 0);
    chk("rw_start", int'(bus.core_start), 0);
    chk("rw_pwm", int'(pwm_out), 0);
    step;
    rst = 1'b0;
    inject_pw = 999;
    inject_req++;
    repeat (4) step;
    chk("rw_done_ignored", int'(dut.pw_target_q), 0);
    chk("rw_still_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
